// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU widths and register-file types
package cpu_pkg;
    localparam int DATA_W     = 8;
    localparam int REG_ADDR_W = 3;
    localparam int NREGS      = 8;

    typedef logic [DATA_W-1:0]     data_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/ld_scoreboard.sv
// rtl/ld_scoreboard.sv - single outstanding load tracking: busy bits, pending flag, cancel
module ld_scoreboard
    import cpu_pkg::*;
#(
    parameter int NREGS = cpu_pkg::NREGS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ld_issue,
    input  logic [REG_ADDR_W-1:0] ld_addr,
    input  logic                  ld_done,
    input  logic                  wr_en,
    input  logic [REG_ADDR_W-1:0] wr_addr,
    input  logic [REG_ADDR_W-1:0] ra_addr,
    input  logic [REG_ADDR_W-1:0] rb_addr,
    output logic                  ld_pending,
    output logic                  ra_busy,
    output logic                  rb_busy,
    output logic                  ld_commit,
    output logic [REG_ADDR_W-1:0] ld_commit_addr
);

    logic [NREGS-1:0] busy_q, busy_d;
    logic             pending_q, pending_d;
    reg_addr_t        addr_q, addr_d;
    logic             accept;
    logic             cancel;

    // Only one load is in flight, so the busy bit at the latched address
    // doubles as the "not cancelled" flag.
    always_comb begin
        accept    = ld_issue && !pending_q;
        cancel    = wr_en && busy_q[wr_addr];
        ld_commit = ld_done && pending_q && busy_q[addr_q] && !cancel;
        busy_d    = busy_q;
        pending_d = pending_q;
        addr_d    = addr_q;
        if (cancel) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (ld_done && pending_q) begin
            busy_d[addr_q] = 1'b0;
            pending_d      = 1'b0;
        end
        if (accept) begin
            busy_d[ld_addr] = 1'b1;
            pending_d       = 1'b1;
            addr_d          = ld_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q    <= '0;
            pending_q <= 1'b0;
            addr_q    <= '0;
        end else begin
            busy_q    <= busy_d;
            pending_q <= pending_d;
            addr_q    <= addr_d;
        end
    end

    assign ld_pending     = pending_q;
    assign ra_busy        = busy_q[ra_addr];
    assign rb_busy        = busy_q[rb_addr];
    assign ld_commit_addr = addr_q;

endmodule

// File: rtl/reg_file_wb.sv
// rtl/reg_file_wb.sv - register file with write-back stage, read bypass and load scoreboard
module reg_file_wb
    import cpu_pkg::*;
#(
    parameter int NREGS = cpu_pkg::NREGS,
    parameter int DW    = cpu_pkg::DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [REG_ADDR_W-1:0] wr_addr,
    input  logic [DW-1:0]         wr_data,
    input  logic [REG_ADDR_W-1:0] ra_addr,
    input  logic [REG_ADDR_W-1:0] rb_addr,
    output logic [DW-1:0]         ra_data,
    output logic [DW-1:0]         rb_data,
    output logic                  ra_busy,
    output logic                  rb_busy,
    input  logic                  ld_issue,
    input  logic [REG_ADDR_W-1:0] ld_addr,
    input  logic                  ld_done,
    input  logic [DW-1:0]         ld_data,
    output logic                  ld_pending
);

    logic [DW-1:0] regs_q [NREGS];
    logic          wb_valid_q;
    reg_addr_t     wb_addr_q;
    logic [DW-1:0] wb_data_q;
    logic          ld_commit;
    reg_addr_t     ld_commit_addr;

    ld_scoreboard #(
        .NREGS(NREGS)
    ) u_ld_scoreboard (
        .clk           (clk),
        .rst           (rst),
        .ld_issue      (ld_issue),
        .ld_addr       (ld_addr),
        .ld_done       (ld_done),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .ra_addr       (ra_addr),
        .rb_addr       (rb_addr),
        .ld_pending    (ld_pending),
        .ra_busy       (ra_busy),
        .rb_busy       (rb_busy),
        .ld_commit     (ld_commit),
        .ld_commit_addr(ld_commit_addr)
    );

    // The load write is placed last so it wins over a same-edge wb commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
        end else begin
            wb_valid_q <= wr_en;
            wb_addr_q  <= wr_addr;
            wb_data_q  <= wr_data;
            if (wb_valid_q) begin
                regs_q[wb_addr_q] <= wb_data_q;
            end
            if (ld_commit) begin
                regs_q[ld_commit_addr] <= ld_data;
            end
        end
    end

    assign ra_data = (wb_valid_q && (wb_addr_q == ra_addr)) ? wb_data_q : regs_q[ra_addr];
    assign rb_data = (wb_valid_q && (wb_addr_q == rb_addr)) ? wb_data_q : regs_q[rb_addr];

endmodule

// File: tb/tb_reg_file_wb.sv
// tb/tb_reg_file_wb.sv - directed scoreboard bench for reg_file_wb
`timescale 1ns/1ps
module tb_reg_file_wb;

    localparam int P_RA_DATA = 0;
    localparam int P_RB_DATA = 1;
    localparam int P_RA_BUSY = 2;
    localparam int P_RB_BUSY = 3;
    localparam int P_PEND    = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic [2:0] ra_addr = '0;
    logic [2:0] rb_addr = '0;
    logic [7:0] ra_data;
    logic [7:0] rb_data;
    logic       ra_busy;
    logic       rb_busy;
    logic       ld_issue = 1'b0;
    logic [2:0] ld_addr = '0;
    logic       ld_done = 1'b0;
    logic [7:0] ld_data = '0;
    logic       ld_pending;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      tag;
        int         port;
        logic [2:0] addr;
        logic [7:0] exp;
    } chk_t;

    chk_t exp_q[$];

    always #50 clk = ~clk;

    reg_file_wb dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .ra_addr   (ra_addr),
        .rb_addr   (rb_addr),
        .ra_data   (ra_data),
        .rb_data   (rb_data),
        .ra_busy   (ra_busy),
        .rb_busy   (rb_busy),
        .ld_issue  (ld_issue),
        .ld_addr   (ld_addr),
        .ld_done   (ld_done),
        .ld_data   (ld_data),
        .ld_pending(ld_pending)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string tag, input int port, input logic [2:0] addr,
                              input logic [7:0] exp);
        chk_t c;
        c.tag  = tag;
        c.port = port;
        c.addr = addr;
        c.exp  = exp;
        exp_q.push_back(c);
    endtask

    task automatic drain();
        chk_t       c;
        logic [7:0] obs;
        while (exp_q.size() > 0) begin
            c       = exp_q.pop_front();
            ra_addr = c.addr;
            rb_addr = c.addr;
            #1;
            case (c.port)
                P_RA_DATA: obs = ra_data;
                P_RB_DATA: obs = rb_data;
                P_RA_BUSY: obs = {7'b0, ra_busy};
                P_RB_BUSY: obs = {7'b0, rb_busy};
                default:   obs = {7'b0, ld_pending};
            endcase
            total++;
            assert (obs === c.exp) else begin
                bad++;
                $error("FAIL %s addr=%0d got=%h want=%h", c.tag, c.addr, obs, c.exp);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int a = 0; a < 8; a++) begin
            expect_val("rst_ra_data", P_RA_DATA, 3'(a), 8'h00);
            expect_val("rst_rb_data", P_RB_DATA, 3'(a), 8'h00);
            expect_val("rst_ra_busy", P_RA_BUSY, 3'(a), 8'h00);
            expect_val("rst_rb_busy", P_RB_BUSY, 3'(a), 8'h00);
        end
        expect_val("rst_pend", P_PEND, 3'd0, 8'h00);
        drain();

        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'h5A;
        step();
        wr_en = 1'b0;
        expect_val("wb_bypass", P_RA_DATA, 3'd3, 8'h5A);
        expect_val("wb_other", P_RA_DATA, 3'd2, 8'h00);
        drain();
        step();
        expect_val("wb_array", P_RA_DATA, 3'd3, 8'h5A);
        expect_val("wb_array_rb", P_RB_DATA, 3'd3, 8'h5A);
        drain();

        ld_issue = 1'b1; ld_addr = 3'd5;
        step();
        ld_addr = 3'd1;
        expect_val("ld5_busy", P_RB_BUSY, 3'd5, 8'h01);
        expect_val("ld5_pend", P_PEND, 3'd0, 8'h01);
        expect_val("ld5_nbusy4", P_RA_BUSY, 3'd4, 8'h00);
        drain();
        step();
        ld_issue = 1'b0;
        expect_val("ld_ignored_busy1", P_RA_BUSY, 3'd1, 8'h00);
        drain();
        ld_done = 1'b1; ld_data = 8'hC3;
        step();
        ld_done = 1'b0;
        expect_val("ld5_data", P_RB_DATA, 3'd5, 8'hC3);
        expect_val("ld5_unbusy", P_RB_BUSY, 3'd5, 8'h00);
        expect_val("ld5_unpend", P_PEND, 3'd0, 8'h00);
        expect_val("ld1_clean", P_RA_DATA, 3'd1, 8'h00);
        drain();

        ld_issue = 1'b1; ld_addr = 3'd2;
        step();
        ld_issue = 1'b0;
        expect_val("ld2_busy", P_RA_BUSY, 3'd2, 8'h01);
        drain();
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'h11;
        step();
        wr_en = 1'b0;
        expect_val("cancel_busy", P_RA_BUSY, 3'd2, 8'h00);
        expect_val("cancel_pend", P_PEND, 3'd0, 8'h01);
        expect_val("cancel_bypass", P_RA_DATA, 3'd2, 8'h11);
        drain();
        ld_done = 1'b1; ld_data = 8'hEE;
        step();
        ld_done = 1'b0;
        expect_val("cancel_done_pend", P_PEND, 3'd0, 8'h00);
        expect_val("cancel_keep", P_RA_DATA, 3'd2, 8'h11);
        drain();
        step();
        expect_val("cancel_keep_arr", P_RB_DATA, 3'd2, 8'h11);
        drain();

        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 8'h01;
        ld_issue = 1'b1; ld_addr = 3'd4;
        step();
        wr_en = 1'b0; ld_issue = 1'b0;
        expect_val("same_busy", P_RA_BUSY, 3'd4, 8'h01);
        expect_val("same_pend", P_PEND, 3'd0, 8'h01);
        expect_val("same_bypass", P_RA_DATA, 3'd4, 8'h01);
        drain();
        ld_done = 1'b1; ld_data = 8'h99;
        ld_issue = 1'b1; ld_addr = 3'd7;
        step();
        ld_done = 1'b0; ld_issue = 1'b0;
        expect_val("same_ld_wins", P_RA_DATA, 3'd4, 8'h99);
        expect_val("same_unbusy", P_RA_BUSY, 3'd4, 8'h00);
        expect_val("same_unpend", P_PEND, 3'd0, 8'h00);
        expect_val("issue_on_done_ign", P_RB_BUSY, 3'd7, 8'h00);
        drain();
        step();
        expect_val("same_ld_arr", P_RB_DATA, 3'd4, 8'h99);
        expect_val("issue_on_done_pend", P_PEND, 3'd0, 8'h00);
        drain();

        ld_done = 1'b1; ld_data = 8'hAB;
        step();
        ld_done = 1'b0;
        expect_val("stray_done4", P_RA_DATA, 3'd4, 8'h99);
        expect_val("stray_done7", P_RA_DATA, 3'd7, 8'h00);
        expect_val("stray_pend", P_PEND, 3'd0, 8'h00);
        drain();

        ld_issue = 1'b1; ld_addr = 3'd6;
        step();
        ld_issue = 1'b0;
        expect_val("ld6_busy", P_RB_BUSY, 3'd6, 8'h01);
        drain();
        rst = 1'b1;
        step();
        rst = 1'b0;
        ld_done = 1'b1; ld_data = 8'h77;
        step();
        ld_done = 1'b0;
        expect_val("rst_ld6_data", P_RA_DATA, 3'd6, 8'h00);
        expect_val("rst_ld6_busy", P_RB_BUSY, 3'd6, 8'h00);
        expect_val("rst_ld6_pend", P_PEND, 3'd0, 8'h00);
        expect_val("rst_reg3", P_RA_DATA, 3'd3, 8'h00);
        expect_val("rst_reg4", P_RB_DATA, 3'd4, 8'h00);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
